rca_nibble_sequencer: RTL and testbench

Multi-cycle wide adder controller that drives the team's 4-bit ripple-carry adder stage, one nibble per clock. It accepts a WIDTH-bit operand pair through a valid/ready handshake. It feeds the adder with successive nibbles from LSB to MSB and chains the carry between cycles through a register. It assembles the adder's sum nibbles into a WIDTH-bit result, which it presents through a valid/ready output handshake. The adder is external and combinational; this block sits directly upstream and downstream of it.

---
 rtl/rca_nibble_sequencer.sv | 114 +++++++++++
 tb/tb_rca_nibble_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder controller: streams operand nibbles LSB-first through an
// external combinational 4-bit ripple-carry stage and reassembles the sum.
module rca_nibble_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_carry,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_carry_in,
    input  logic [3:0]       add_sum,
    input  logic             add_carry_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             busy
);

    localparam int unsigned N  = WIDTH / 4;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_out_carry;
    logic [KW-1:0]    r_k;
    logic [KW+1:0]    w_base;
    logic             w_last;
    logic             w_run;

    assign w_base = {r_k, 2'b00};
    assign w_last = (r_k == KW'(N - 1));
    assign w_run  = (r_state == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    // Carry between nibbles lives in r_carry; the final one is latched separately
    // so out_carry stays stable through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_out_carry <= 1'b0;
            r_k         <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op_a   <= in_a;
                        r_op_b   <= in_b;
                        r_carry  <= in_carry;
                        r_k      <= '0;
                        r_result <= '0;
                    end
                end
                S_RUN: begin
                    r_result[w_base +: 4] <= add_sum;
                    r_carry               <= add_carry_out;
                    if (w_last) begin
                        r_k         <= '0;
                        r_out_carry <= add_carry_out;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign add_a        = w_run ? r_op_a[w_base +: 4] : 4'h0;
    assign add_b        = w_run ? r_op_b[w_base +: 4] : 4'h0;
    assign add_carry_in = w_run ? r_carry : 1'b0;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_sum   = r_result;
    assign out_carry = r_out_carry;

endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// Scoreboard bench for rca_nibble_sequencer: a 16-bit and a 4-bit instance, each
// closed around a behavioural 4-bit adder.
module tb_rca_nibble_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 16-bit instance
    logic        in_valid, in_ready, in_carry, add_ci, add_co, out_valid, out_ready, out_carry, busy;
    logic [15:0] in_a, in_b, out_sum;
    logic [3:0]  add_a, add_b, add_s;

    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_ci};

    rca_nibble_sequencer #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_carry(in_carry),
        .add_a(add_a), .add_b(add_b), .add_carry_in(add_ci),
        .add_sum(add_s), .add_carry_out(add_co),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .busy(busy)
    );

    // 4-bit instance
    logic       v4, r4, c4, ci4, co4, ov4, or4, oc4, busy4;
    logic [3:0] a4, b4, os4, aa4, ab4, as4;

    assign {co4, as4} = {1'b0, aa4} + {1'b0, ab4} + {4'b0, ci4};

    rca_nibble_sequencer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v4), .in_ready(r4),
        .in_a(a4), .in_b(b4), .in_carry(c4),
        .add_a(aa4), .add_b(ab4), .add_carry_in(ci4),
        .add_sum(as4), .add_carry_out(co4),
        .out_valid(ov4), .out_ready(or4),
        .out_sum(os4), .out_carry(oc4), .busy(busy4)
    );

    logic [16:0] q16[$];
    logic [4:0]  q4[$];

    task automatic accept16(input logic [15:0] a, input logic [15:0] b, input logic c);
        bit ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_carry = c;
        for (int i = 0; i < 20; i++) begin
            if (in_ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        q16.push_back({1'b0, a} + {1'b0, b} + {16'b0, c});
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = ~a; in_b = ~b; in_carry = ~c;
    endtask

    task automatic release16();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL release_idle: in_ready=%b out_valid=%b busy=%b required 1 0 0",
                     in_ready, out_valid, busy);
        end
        out_ready = 1'b0;
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic       cc;
        logic [4:0] s;
        logic [16:0] e;
        accept16(a, b, c);
        cc = c;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (add_a !== a[4*k +: 4] || add_b !== b[4*k +: 4] || add_ci !== cc) begin
                errors++;
                $display("FAIL run_nibble%0d: add_a=%h add_b=%h add_ci=%b required %h %h %b",
                         k, add_a, add_b, add_ci, a[4*k +: 4], b[4*k +: 4], cc);
            end
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL run_flags%0d: out_valid=%b busy=%b in_ready=%b required 0 1 0",
                         k, out_valid, busy, in_ready);
            end
            s  = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]} + {4'b0, cc};
            cc = s[4];
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: out_valid=%b required 1 at edge 4", out_valid);
        end
        checks++;
        if (q16.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: size=0 required >0");
        end else begin
            e = q16.pop_front();
            if (out_sum !== e[15:0] || out_carry !== e[16]) begin
                errors++;
                $display("FAIL result %h+%h+%b: sum=%h carry=%b required %h %b",
                         a, b, c, out_sum, out_carry, e[15:0], e[16]);
            end
        end
        release16();
    endtask

    task automatic test_reset();
        in_valid = 1'b1; in_a = 16'hAAAA; in_b = 16'h5555; in_carry = 1'b1; out_ready = 1'b0;
        v4 = 1'b1; a4 = 4'h3; b4 = 4'h4; c4 = 1'b0; or4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_sum !== 16'h0 ||
            out_carry !== 1'b0 || add_a !== 4'h0 || add_b !== 4'h0 || add_ci !== 1'b0) begin
            errors++;
            $display("FAIL reset16: rdy=%b busy=%b ov=%b sum=%h c=%b a=%h b=%h ci=%b required 1 0 0 0000 0 0 0 0",
                     in_ready, busy, out_valid, out_sum, out_carry, add_a, add_b, add_ci);
        end
        checks++;
        if (r4 !== 1'b1 || busy4 !== 1'b0 || ov4 !== 1'b0 || os4 !== 4'h0 || oc4 !== 1'b0) begin
            errors++;
            $display("FAIL reset4: rdy=%b busy=%b ov=%b sum=%h c=%b required 1 0 0 0 0",
                     r4, busy4, ov4, os4, oc4);
        end
        in_valid = 1'b0; v4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b busy4=%b required 0 0", busy, busy4);
        end
    endtask

    task automatic test_basic_add();
        run16(16'h1234, 16'h4321, 1'b0);
    endtask

    task automatic test_carry_ripple();
        run16(16'hFFFF, 16'h0001, 1'b0);
    endtask

    task automatic test_carry_in();
        run16(16'hFFFF, 16'hFFFF, 1'b1);
        run16(16'h0000, 16'h0000, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [16:0] e;
        accept16(16'hBEEF, 16'h1111, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        e = (q16.size() > 0) ? q16.pop_front() : 17'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = i[0];
            in_a = 16'h0F0F ^ 16'(i); in_b = 16'h7777; in_carry = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== e[15:0] || out_carry !== e[16]) begin
                errors++;
                $display("FAIL backpressure%0d: ov=%b rdy=%b sum=%h c=%b required 1 0 %h %b",
                         i, out_valid, in_ready, out_sum, out_carry, e[15:0], e[16]);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        release16();
        run16(16'h8001, 16'h7FFF, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        accept16(16'h1357, 16'h2468, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (add_a !== 4'h3) begin
            errors++;
            $display("FAIL mid_op_k2: add_a=%h required 3", add_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_sum !== 16'h0 ||
            out_carry !== 1'b0 || add_a !== 4'h0 || add_b !== 4'h0 || add_ci !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_op: rdy=%b busy=%b ov=%b sum=%h c=%b a=%h b=%h ci=%b required 1 0 0 0000 0 0 0 0",
                     in_ready, busy, out_valid, out_sum, out_carry, add_a, add_b, add_ci);
        end
        void'(q16.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL aborted_no_output: ov=%b busy=%b required 0 0", out_valid, busy);
            end
        end
        run16(16'h00FF, 16'h0001, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_width4();
        logic [3:0] ta[3];
        logic [3:0] tb[3];
        logic       tc[3];
        logic [4:0] e;
        bit         ok;
        ta = '{4'hF, 4'h7, 4'h9}; tb = '{4'h1, 4'h8, 4'h6}; tc = '{1'b0, 1'b1, 1'b1};
        for (int t = 0; t < 3; t++) begin
            ok = 1'b0;
            @(negedge clk);
            v4 = 1'b1; a4 = ta[t]; b4 = tb[t]; c4 = tc[t];
            for (int i = 0; i < 20; i++) begin
                if (r4 === 1'b1) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL w4_accept_timeout: in_ready=%b required 1", r4);
            end
            q4.push_back({1'b0, ta[t]} + {1'b0, tb[t]} + {4'b0, tc[t]});
            @(posedge clk); #1;
            v4 = 1'b0; a4 = ~ta[t];
            checks++;
            if (aa4 !== ta[t] || ab4 !== tb[t] || ci4 !== tc[t] || ov4 !== 1'b0) begin
                errors++;
                $display("FAIL w4_run%0d: a=%h b=%h ci=%b ov=%b required %h %h %b 0",
                         t, aa4, ab4, ci4, ov4, ta[t], tb[t], tc[t]);
            end
            @(posedge clk); #1;
            e = q4.pop_front();
            checks++;
            if (ov4 !== 1'b1 || os4 !== e[3:0] || oc4 !== e[4]) begin
                errors++;
                $display("FAIL w4_result%0d: ov=%b sum=%h c=%b required 1 %h %b",
                         t, ov4, os4, oc4, e[3:0], e[4]);
            end
            @(negedge clk);
            or4 = 1'b1;
            @(posedge clk); #1;
            or4 = 1'b0;
            checks++;
            if (r4 !== 1'b1 || ov4 !== 1'b0) begin
                errors++;
                $display("FAIL w4_release%0d: rdy=%b ov=%b required 1 0", t, r4, ov4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_carry_ripple();
        test_carry_in();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        test_width4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
